keypad_timer_sequencer: RTL and testbench

- Parametrised successor to the microwave keypad/timer front end.
- Merges key encoding, debounce, delayed load strobe, the tick divider and pgt source selection into one synchronous block.
- Adds what the previous generation lacks:
  - key debouncing
  - one load per press, with release detection
  - a configurable key count, divider ratio and load delay
  - a clean abort when the mode changes mid-entry
- Sits between the physical keypad and the BCD timer; drives the timer's digit, loadn and pgt inputs.

---
 rtl/keypad_timer_sequencer.sv | 164 ++++++++++++++++
 tb/tb_keypad_timer_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_timer_sequencer.sv
// Purpose: keypad front end for the BCD timer. It encodes, debounces and delays each key press into one load strobe, and divides the clock into run-mode ticks.
// Latency: loadn goes low DEBOUNCE_CYC+LOAD_DELAY edges after the first key sample. pgt ticks every TICK_DIV cycles in run mode.
// Backpressure: none. The keypad is sampled every cycle, and a held key must be fully released before it can be accepted again.
//
// Ports:
//   clock    rising-edge system clock
//   reset    synchronous, active-high
//   keypad   raw active-high key lines; key i encodes to digit i; the highest index wins
//   enablen  0 = entry mode (keypad active), 1 = run mode (tick divider active)
//   digit    registered code of the last accepted key
//   loadn    active-low load strobe, one cycle per accepted press
//   pgt      timer clock pulse: coincides with loadn in entry mode, tick pulse in run mode
module keypad_timer_sequencer #(
    parameter int NUM_KEYS     = 10,
    parameter int DIGIT_W      = 4,
    parameter int DEBOUNCE_CYC = 4,
    parameter int LOAD_DELAY   = 2,
    parameter int TICK_DIV     = 100
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keypad,
    input  logic                enablen,
    output logic [DIGIT_W-1:0]  digit,
    output logic                loadn,
    output logic                pgt
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam int LW = (LOAD_DELAY > 1) ? $clog2(LOAD_DELAY) : 1;
    localparam int VW = $clog2(TICK_DIV);

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC);
    localparam logic [CW-1:0] REL_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic [LW-1:0] DLY_LAST = LW'((LOAD_DELAY > 0) ? LOAD_DELAY - 1 : 0);
    localparam logic [VW-1:0] DIV_LAST = VW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        DELAY,
        LOAD,
        RELEASE
    } state_t;

    state_t             state, state_nxt;
    logic [DIGIT_W-1:0] cand, cand_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [LW-1:0]      dly, dly_nxt;
    logic [VW-1:0]      div;
    logic               run_q;
    logic [DIGIT_W-1:0] key_code;
    logic               key_any;

    // Priority encoder: the last asserted bit in index order wins.
    always_comb begin
        key_code = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keypad[i]) key_code = DIGIT_W'(i);
        end
    end

    assign key_any = |keypad;

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        dly_nxt   = dly;
        if (enablen) begin
            // Run mode parks the sequencer. This also aborts any press that is in flight.
            state_nxt = IDLE;
            cnt_nxt   = '0;
            dly_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_any) begin
                        cand_nxt  = key_code;
                        cnt_nxt   = CW'(1);
                        state_nxt = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!key_any || key_code != cand) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        dly_nxt   = '0;
                        state_nxt = (LOAD_DELAY == 0) ? LOAD : DELAY;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                DELAY: begin
                    if (dly == DLY_LAST) begin
                        dly_nxt   = '0;
                        state_nxt = LOAD;
                    end else begin
                        dly_nxt = dly + LW'(1);
                    end
                end
                LOAD: begin
                    cnt_nxt   = '0;
                    state_nxt = RELEASE;
                end
                RELEASE: begin
                    // Any key activity restarts the quiet-time count.
                    if (key_any) begin
                        cnt_nxt = '0;
                    end else if (cnt == REL_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    dly_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
            dly   <= '0;
            div   <= '0;
            run_q <= 1'b0;
            digit <= '0;
            loadn <= 1'b1;
            pgt   <= 1'b0;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            cnt   <= cnt_nxt;
            dly   <= dly_nxt;
            run_q <= enablen;
            if (enablen) begin
                loadn <= 1'b1;
                // The first run-mode edge only arms the divider. That places the first tick exactly TICK_DIV edges later.
                if (run_q) begin
                    div <= (div == DIV_LAST) ? '0 : div + VW'(1);
                    pgt <= (div == DIV_LAST);
                end else begin
                    div <= '0;
                    pgt <= 1'b0;
                end
            end else begin
                div   <= '0;
                loadn <= (state_nxt != LOAD);
                pgt   <= (state_nxt == LOAD);
                if (state_nxt == LOAD) digit <= cand_nxt;
            end
        end
    end

endmodule

// File: tb/tb_keypad_timer_sequencer.sv
// Purpose: self-checking bench for keypad_timer_sequencer. It uses directed scenarios plus randomized key and mode traffic.
// Latency: outputs are compared 1 time unit after every rising edge.
// Backpressure: not applicable.
module tb_keypad_timer_sequencer;

    localparam int NK = 10;
    localparam int DW = 4;
    localparam int DB = 4;
    localparam int LD = 2;
    localparam int TD = 10;

    logic          clock = 1'b0;
    logic          reset;
    logic [NK-1:0] keypad;
    logic          enablen;
    logic [DW-1:0] digit;
    logic          loadn;
    logic          pgt;

    keypad_timer_sequencer #(
        .NUM_KEYS    (NK),
        .DIGIT_W     (DW),
        .DEBOUNCE_CYC(DB),
        .LOAD_DELAY  (LD),
        .TICK_DIV    (TD)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .keypad (keypad),
        .enablen(enablen),
        .digit  (digit),
        .loadn  (loadn),
        .pgt    (pgt)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model. A press is tracked by the edge of its first sample.
    // The load is due at first_edge + DB + LD.
    // Release needs DB consecutive empty samples.
    // Ticks fall on every TD-th run-mode edge, counted from the first run-mode edge.
    int            edge_no = 0;
    int            m_phase = 0;      // 0 = searching, 1 = load scheduled, 2 = awaiting release
    int            m_start = -1;
    int            m_code  = 0;
    int            m_load_at = 0;
    int            m_zero  = 0;
    int            m_run_n = 0;
    bit            m_run_prev = 0;
    logic [DW-1:0] exp_digit = '0;
    logic          exp_loadn = 1'b1;
    logic          exp_pgt   = 1'b0;

    function automatic int enc(input logic [NK-1:0] kp);
        int c;
        c = -1;
        for (int i = 0; i < NK; i++) if (kp[i]) c = i;
        return c;
    endfunction

    task automatic model_edge(input logic [NK-1:0] kp, input logic en, input logic rst);
        int code;
        edge_no++;
        if (rst) begin
            m_phase = 0; m_start = -1; m_run_prev = 0; m_run_n = 0;
            exp_digit = '0; exp_loadn = 1'b1; exp_pgt = 1'b0;
            return;
        end
        exp_loadn = 1'b1;
        exp_pgt   = 1'b0;
        if (en) begin
            m_phase = 0; m_start = -1;
            m_run_n = m_run_prev ? m_run_n + 1 : 0;
            exp_pgt = (m_run_n > 0) && (m_run_n % TD == 0);
            m_run_prev = 1;
            return;
        end
        m_run_prev = 0;
        code = enc(kp);
        case (m_phase)
            0: begin
                if (m_start < 0) begin
                    if (code >= 0) begin m_start = edge_no; m_code = code; end
                end else if (code != m_code) begin
                    m_start = -1;
                end else if (edge_no - m_start == DB) begin
                    m_load_at = m_start + DB + LD;
                    m_phase = 1;
                end
            end
            2: begin
                m_zero = (code < 0) ? m_zero + 1 : 0;
                if (m_zero == DB) begin m_phase = 0; m_start = -1; end
            end
            default: ;
        endcase
        if (m_phase == 1 && edge_no == m_load_at) begin
            exp_loadn = 1'b0;
            exp_pgt   = 1'b1;
            exp_digit = DW'(m_code);
            m_phase   = 2;
            m_zero    = 0;
        end
    endtask

    int step_no = 0;
    int loads = 0;
    int pgts = 0;
    int last_load_step = -1;
    int first_pgt_step = -1;

    task automatic step(input logic [NK-1:0] kp, input logic en, input logic rst);
        keypad = kp; enablen = en; reset = rst;
        @(posedge clock);
        model_edge(kp, en, rst);
        #1;
        step_no++;
        check("digit", 32'(digit), 32'(exp_digit));
        check("loadn", 32'(loadn), 32'(exp_loadn));
        check("pgt",   32'(pgt),   32'(exp_pgt));
        if (!loadn) begin loads++; last_load_step = step_no; end
        if (pgt) begin pgts++; if (first_pgt_step < 0) first_pgt_step = step_no; end
    endtask

    initial begin
        int            base;
        int            len;
        int            r;
        logic [NK-1:0] kp;
        logic          en;
        logic          rst;
        logic [NK-1:0] bounce;

        // Reset with every key asserted.
        for (int i = 0; i < 3; i++) step(10'h3FF, 1'b0, 1'b1);
        step(10'h000, 1'b0, 1'b0);
        check("post_reset_digit", 32'(digit), 32'd0);
        step(10'h000, 1'b0, 1'b0);

        // Clean press of key 5.
        loads = 0; base = step_no + 1;
        for (int i = 0; i < 20; i++) step(10'h020, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(10'h000, 1'b0, 1'b0);
        check("clean_loads", 32'(loads), 32'd1);
        check("clean_offset", 32'(last_load_step - base), 32'd6);
        check("clean_digit", 32'(digit), 32'd5);

        // Bounce on key 3.
        loads = 0;
        bounce = 10'b1_0110;
        for (int i = 4; i >= 0; i--) step(bounce[i] ? 10'h008 : 10'h000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(10'h000, 1'b0, 1'b0);
        check("bounce_loads", 32'(loads), 32'd0);
        check("bounce_digit", 32'(digit), 32'd5);

        // Keys 3 and 7 held together. A short release must not allow a second load.
        loads = 0;
        for (int i = 0; i < 50; i++) step(10'h088, 1'b0, 1'b0);
        check("prio_digit", 32'(digit), 32'd7);
        check("hold_loads", 32'(loads), 32'd1);
        for (int i = 0; i < 3; i++) step(10'h000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(10'h088, 1'b0, 1'b0);
        check("short_release_loads", 32'(loads), 32'd1);
        for (int i = 0; i < 4; i++) step(10'h000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(10'h088, 1'b0, 1'b0);
        check("repress_loads", 32'(loads), 32'd2);
        for (int i = 0; i < 6; i++) step(10'h000, 1'b0, 1'b0);

        // Run-mode ticks.
        loads = 0; pgts = 0; first_pgt_step = -1; base = step_no + 1;
        for (int i = 0; i < 35; i++) step(10'h000, 1'b1, 1'b0);
        check("run_pgt_count", 32'(pgts), 32'd3);
        check("run_first_tick", 32'(first_pgt_step - base), 32'(TD));
        check("run_loads", 32'(loads), 32'd0);
        for (int i = 0; i < 3; i++) step(10'h000, 1'b0, 1'b0);

        // Abort: key 2 is pressed, then run mode starts at the fourth sample.
        loads = 0;
        for (int i = 0; i < 3; i++) step(10'h004, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(10'h004, 1'b1, 1'b0);
        check("abort_loads", 32'(loads), 32'd0);
        check("abort_digit", 32'(digit), 32'd7);

        // Reset with the divider at 6.
        step(10'h000, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(10'h000, 1'b1, 1'b0);
        step(10'h000, 1'b1, 1'b1);
        check("rst_digit", 32'(digit), 32'd0);
        first_pgt_step = -1; base = step_no + 1;
        for (int i = 0; i < 25; i++) step(10'h000, 1'b1, 1'b0);
        check("rst_first_tick", 32'(first_pgt_step - base), 32'(TD));
        step(10'h000, 1'b0, 1'b0);

        // Randomized traffic against the model.
        for (int seg = 0; seg < 220; seg++) begin
            r   = $urandom_range(0, 99);
            len = $urandom_range(1, 12);
            en  = 1'b0;
            rst = 1'b0;
            if (r < 8) begin
                en  = 1'b1;
                len = $urandom_range(5, 25);
            end else if (r < 11) begin
                rst = 1'b1;
                len = 1;
            end
            kp = '0;
            case ($urandom_range(0, 3))
                0: kp = '0;
                3: begin
                    kp[$urandom_range(0, NK-1)] = 1'b1;
                    kp[$urandom_range(0, NK-1)] = 1'b1;
                end
                default: kp[$urandom_range(0, NK-1)] = 1'b1;
            endcase
            for (int j = 0; j < len; j++) step(kp, en, rst);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
